// File: rtl/ex_mem_if.sv
// ex_mem_if: EX/MEM stage bus; master drives EX-side inputs, slave is the stage.
interface ex_mem_if;
  logic        stall;
  logic        flush;
  logic [31:0] instr_E;
  logic [31:0] pc_E;
  logic [31:0] alu_E;
  logic [31:0] rt_E;
  logic [31:0] instr_M;
  logic [31:0] pc_M;
  logic [31:0] alu_M;
  logic [31:0] rd_data_M;
  logic [4:0]  a3_M;
  logic        reg_write_M;
  logic [31:0] wd_M;
  logic [31:0] fwd_M;
  modport master (
    output stall, flush, instr_E, pc_E, alu_E, rt_E,
    input  instr_M, pc_M, alu_M, rd_data_M, a3_M, reg_write_M, wd_M, fwd_M
  );
  modport slave (
    input  stall, flush, instr_E, pc_E, alu_E, rt_E,
    output instr_M, pc_M, alu_M, rd_data_M, a3_M, reg_write_M, wd_M, fwd_M
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register, word-addressed data memory and write-back select.
module ex_mem_stage #(
  parameter int DM_WORDS = 1024,
  parameter int AW       = 10
) (
  input logic     clk,
  input logic     reset,
  ex_mem_if.slave bus
);
  logic [31:0] instr_q, pc_q, alu_q, rt_q;
  logic [31:0] instr_d, pc_d, alu_d, rt_d;
  logic [31:0] mem_q [DM_WORDS];
  logic [5:0]  op, funct;
  logic [AW-1:0] addr;
  logic [31:0] pc8;
  logic        r_op, is_lw, is_sw, is_jal, is_ori, is_lui, r_wr;
  always_comb begin
    instr_d = bus.flush ? 32'd0 : bus.stall ? instr_q : bus.instr_E;
    pc_d    = bus.flush ? 32'd0 : bus.stall ? pc_q    : bus.pc_E;
    alu_d   = bus.flush ? 32'd0 : bus.stall ? alu_q   : bus.alu_E;
    rt_d    = bus.flush ? 32'd0 : bus.stall ? rt_q    : bus.rt_E;
  end
  assign op     = instr_q[31:26];
  assign funct  = instr_q[5:0];
  assign r_op   = op == 6'b000000;
  assign is_ori = op == 6'b001101;
  assign is_lw  = op == 6'b100011;
  assign is_sw  = op == 6'b101011;
  assign is_lui = op == 6'b001111;
  assign is_jal = op == 6'b000011;
  assign r_wr   = r_op && (funct == 6'b100001 || funct == 6'b100011 || funct == 6'b000000);
  assign addr   = alu_q[AW+1:2];
  assign pc8    = pc_q + 32'd8;
  // Reset clears the whole memory too, so an in-flight sw never lands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      rt_q    <= '0;
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      rt_q    <= rt_d;
      if (is_sw) mem_q[addr] <= rt_q;
    end
  end
  assign bus.instr_M     = instr_q;
  assign bus.pc_M        = pc_q;
  assign bus.alu_M       = alu_q;
  assign bus.rd_data_M   = mem_q[addr];
  assign bus.a3_M        = r_wr ? instr_q[15:11] : (is_ori || is_lw || is_lui) ? instr_q[20:16] : is_jal ? 5'd31 : 5'd0;
  assign bus.reg_write_M = bus.a3_M != 5'd0;
  assign bus.wd_M        = is_lw ? bus.rd_data_M : is_jal ? pc8 : alu_q;
  assign bus.fwd_M       = is_jal ? pc8 : alu_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vector table plus hand-written stall/flush/reset sequences.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  ex_mem_if bus();
  ex_mem_stage #(.DM_WORDS(1024), .AW(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic st, fl;
    logic [31:0] ins, pc, alu, rt;
    logic [4:0] a3;
    logic rw;
    logic [31:0] wd, fwd, rd;
  } vec_t;
  vec_t v[16];
  function automatic logic [31:0] rt_(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'b0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction
  function automatic logic [31:0] it_(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step(input logic st, input logic fl, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] alu, input logic [31:0] rt);
    bus.stall = st; bus.flush = fl; bus.instr_E = ins; bus.pc_E = pc; bus.alu_E = alu; bus.rt_E = rt;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string n, input logic [31:0] ins, input logic [4:0] a3, input logic rw,
                         input logic [31:0] wd, input logic [31:0] fwd, input logic [31:0] rd);
    chk({n, ".instr"}, bus.instr_M, ins);
    chk({n, ".a3"}, {27'd0, bus.a3_M}, {27'd0, a3});
    chk({n, ".rw"}, {31'd0, bus.reg_write_M}, {31'd0, rw});
    chk({n, ".wd"}, bus.wd_M, wd);
    chk({n, ".fwd"}, bus.fwd_M, fwd);
    chk({n, ".rd"}, bus.rd_data_M, rd);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    logic [31:0] addu5, sw_i;
    addu5 = rt_(1, 2, 5, 6'h21);
    v[0]  = '{0, 0, addu5, 32'h100, 32'd7, 32'd0, 5'd5, 1, 32'd7, 32'd7, 32'd0};
    v[1]  = '{0, 0, it_(6'h2b, 0, 9, 16'h10), 32'h104, 32'h10, 32'hDEADBEEF, 5'd0, 0, 32'h10, 32'h10, 32'd0};
    v[2]  = '{0, 0, it_(6'h23, 0, 9, 16'h10), 32'h108, 32'h10, 32'd0, 5'd9, 1, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF};
    v[3]  = '{0, 0, it_(6'h2b, 0, 1, 16'h1003), 32'h10c, 32'h1003, 32'h12345678, 5'd0, 0, 32'h1003, 32'h1003, 32'd0};
    v[4]  = '{0, 0, it_(6'h23, 0, 8, 16'h0), 32'h110, 32'h0, 32'd0, 5'd8, 1, 32'h12345678, 32'h0, 32'h12345678};
    v[5]  = '{0, 0, {6'h03, 26'h10}, 32'h3000, 32'h55, 32'd0, 5'd31, 1, 32'h3008, 32'h3008, 32'd0};
    v[6]  = '{0, 0, {6'h03, 26'h20}, 32'hFFFFFFFC, 32'h0, 32'd0, 5'd31, 1, 32'h4, 32'h4, 32'h12345678};
    v[7]  = '{0, 0, it_(6'h0d, 1, 0, 16'hff), 32'h200, 32'hff, 32'd0, 5'd0, 0, 32'hff, 32'hff, 32'd0};
    v[8]  = '{0, 0, it_(6'h0d, 1, 3, 16'hff), 32'h204, 32'hff, 32'd0, 5'd3, 1, 32'hff, 32'hff, 32'd0};
    v[9]  = '{0, 0, it_(6'h0f, 0, 4, 16'h1234), 32'h208, 32'h12340000, 32'd0, 5'd4, 1, 32'h12340000, 32'h12340000, 32'h12345678};
    v[10] = '{0, 0, it_(6'h04, 1, 2, 16'h3), 32'h20c, 32'h8, 32'd0, 5'd0, 0, 32'h8, 32'h8, 32'd0};
    v[11] = '{0, 0, rt_(31, 0, 5, 6'h08), 32'h210, 32'h20, 32'd0, 5'd0, 0, 32'h20, 32'h20, 32'd0};
    v[12] = '{0, 0, rt_(1, 2, 6, 6'h23), 32'h214, 32'h3, 32'd0, 5'd6, 1, 32'h3, 32'h3, 32'h12345678};
    v[13] = '{0, 0, rt_(0, 2, 7, 6'h00), 32'h218, 32'h40, 32'd0, 5'd7, 1, 32'h40, 32'h40, 32'd0};
    v[14] = '{0, 1, addu5, 32'h21c, 32'h9, 32'd0, 5'd0, 0, 32'd0, 32'd0, 32'h12345678};
    v[15] = '{0, 0, rt_(1, 2, 5, 6'h20), 32'h220, 32'h44, 32'd0, 5'd0, 0, 32'h44, 32'h44, 32'd0};
    bus.stall = 0; bus.flush = 0; bus.instr_E = '0; bus.pc_E = '0; bus.alu_E = '0; bus.rt_E = '0;
    reset = 0;
    step(1, 1, addu5, 32'h50, 32'h7, 32'h9);
    step(0, 0, addu5, 32'h50, 32'h7, 32'h9);
    chk_out("reset", 32'd0, 5'd0, 0, 32'd0, 32'd0, 32'd0);
    chk("reset.pc", bus.pc_M, 32'd0);
    chk("reset.alu", bus.alu_M, 32'd0);
    reset = 1;
    for (int i = 0; i < 16; i++) begin
      step(v[i].st, v[i].fl, v[i].ins, v[i].pc, v[i].alu, v[i].rt);
      chk_out($sformatf("vec%0d", i), v[i].fl ? 32'd0 : v[i].ins, v[i].a3, v[i].rw, v[i].wd, v[i].fwd, v[i].rd);
      chk($sformatf("vec%0d.pc", i), bus.pc_M, v[i].fl ? 32'd0 : v[i].pc);
    end
    step(0, 0, addu5, 32'h300, 32'd7, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, it_(6'h23, 0, 3, 16'h0), 32'h400 + i, 32'h0, 32'h55);
      chk_out($sformatf("stall%0d", i), addu5, 5'd5, 1, 32'd7, 32'd7, 32'd0);
      chk($sformatf("stall%0d.pc", i), bus.pc_M, 32'h300);
    end
    step(1, 1, addu5, 32'h500, 32'd7, 32'd0);
    chk_out("flush_stall", 32'd0, 5'd0, 0, 32'd0, 32'd0, 32'h12345678);
    sw_i = it_(6'h2b, 0, 2, 16'h30);
    step(0, 0, sw_i, 32'h600, 32'h30, 32'hA5A5A5A5);
    chk("sw_hold0.rd", bus.rd_data_M, 32'd0);
    step(1, 0, addu5, 32'h604, 32'h0, 32'h0);
    chk_out("sw_hold1", sw_i, 5'd0, 0, 32'h30, 32'h30, 32'hA5A5A5A5);
    step(1, 0, addu5, 32'h604, 32'h0, 32'h0);
    chk_out("sw_hold2", sw_i, 5'd0, 0, 32'h30, 32'h30, 32'hA5A5A5A5);
    step(0, 0, it_(6'h23, 0, 2, 16'h30), 32'h608, 32'h30, 32'h0);
    chk_out("sw_hold_lw", it_(6'h23, 0, 2, 16'h30), 5'd2, 1, 32'hA5A5A5A5, 32'h30, 32'hA5A5A5A5);
    step(0, 0, it_(6'h2b, 0, 2, 16'h20), 32'h700, 32'h20, 32'hFFFF);
    reset = 0;
    step(0, 0, addu5, 32'h704, 32'd7, 32'd0);
    chk_out("rst_sw", 32'd0, 5'd0, 0, 32'd0, 32'd0, 32'd0);
    reset = 1;
    step(0, 0, it_(6'h23, 0, 2, 16'h20), 32'h708, 32'h20, 32'd0);
    chk_out("rst_lw", it_(6'h23, 0, 2, 16'h20), 5'd2, 1, 32'd0, 32'h20, 32'd0);
    chk("rst_lw0.rd", dut.mem_q[0], 32'd0);
    step(0, 0, addu5, 32'h800, 32'd7, 32'd0);
    reset = 0;
    step(1, 0, addu5, 32'h804, 32'd7, 32'd0);
    chk("rst_stall.instr", bus.instr_M, 32'd0);
    reset = 1;
    step(0, 0, it_(6'h0d, 1, 3, 16'h5), 32'h808, 32'h5, 32'd0);
    chk_out("rst_stall_resume", it_(6'h0d, 1, 3, 16'h5), 5'd3, 1, 32'h5, 32'h5, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DM_WORDS, 1024, data memory depth in 32-bit words (power of 2).
REQ-002 Parameter AW, 10, word-address width, log2(DM_WORDS).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 stall  input  1  hold: EX/MEM register keeps its contents.
REQ-006 flush  input  1  load a bubble (all-zero instruction) into EX/MEM register.
REQ-007 instr_E  input  32  instruction leaving EX.
REQ-008 pc_E  input  32  PC of that instruction.
REQ-009 alu_E  input  32  ALU result from EX.
REQ-010 rt_E  input  32  forwarded rt value, store data for sw.
REQ-011 instr_M  output  32  registered instruction in MEM.
REQ-012 pc_M  output  32  registered PC.
REQ-013 alu_M  output  32  registered ALU result.
REQ-014 rd_data_M  output  32  data memory read data at alu_M.
REQ-015 a3_M  output  5  destination register number.
REQ-016 reg_write_M  output  1  MEM instruction writes the register file.
REQ-017 wd_M  output  32  write-back value.
REQ-018 fwd_M  output  32  bypass value for EX operands; never memory data.

Function
REQ-019 Each edge, reset high: flush=1 -> instr/pc/alu/rt registers load 0; else stall=1 -> registers hold; else they load instr_E, pc_E, alu_E, rt_E.
REQ-020 Priority: reset > flush > stall > normal load.
REQ-021 Decode from instr_M: op=[31:26], funct=[5:0], rt=[20:16], rd=[15:11]; ROp=000000, ori=001101, lw=100011, sw=101011, beq=000100, lui=001111, jal=000011; addu=100001, subu=100011, sll=000000, jr=001000.
REQ-022 a3_M: ROp with funct addu/subu/sll -> rd; ori/lw/lui -> rt; jal -> 31; others -> 0.
REQ-023 reg_write_M = 1 iff a3_M != 0; writes to $0 are suppressed.
REQ-024 Memory word address = alu_M[AW+1:2]; bits [1:0] and bits above AW+1 ignored (wrap modulo DM_WORDS).
REQ-025 rd_data_M = mem[word address], combinational, every cycle regardless of op.
REQ-026 Memory write: at rising edge with reset high and op=sw, mem[word address] <= registered rt; one write per edge; written data visible on rd_data_M the following cycle.
REQ-027 sw held by stall re-writes the same word with the same data each held cycle; no other side effect.
REQ-028 wd_M: lw -> rd_data_M; jal -> pc_M+8 (32-bit wrap); otherwise alu_M.
REQ-029 fwd_M: jal -> pc_M+8; otherwise alu_M.
REQ-030 Zero instruction (sll $0,$0,0) is the bubble: reg_write_M=0, no memory write.
REQ-031 flush and stall both high: bubble loaded, stall ignored.
REQ-032 Latency: EX inputs appear on MEM outputs exactly one edge later, absent stall/flush.

Reset
REQ-033 Edge with reset=0: instr_M, pc_M, alu_M, stored rt all 0; every memory word 0; overrides flush, stall and any in-flight sw.
REQ-034 After reset: a3_M=0, reg_write_M=0, wd_M=0, fwd_M=0, rd_data_M=0.
REQ-035 Reset asserted mid-stall discards held instruction; first edge with reset=1 loads per REQ-019.

Verification
REQ-036 sw then lw: sw $t1 (rt_E=0xDEADBEEF, alu_E=0x10), next lw alu_E=0x10 rt=9 -> lw cycle rd_data_M=wd_M=0xDEADBEEF, a3_M=9, reg_write_M=1.
REQ-037 Wrap/alignment: sw alu_E=0x1003 data 0x12345678, then lw alu_E=0x0 -> rd_data_M=0x12345678 (word 0).
REQ-038 jal pc_E=0x3000 -> a3_M=31, wd_M=fwd_M=0x3008, reg_write_M=1.
REQ-039 Stall 3 cycles holding addu rd=5 alu_E=7 while inputs change -> outputs constant (a3_M=5, wd_M=7); flush+stall same edge -> instr_M=0, reg_write_M=0.
REQ-040 Reset low one edge after a sw to 0x20 with 0xFFFF -> all outputs 0; subsequent lw 0x20 returns 0.
REQ-041 ori with rt=0 -> a3_M=0, reg_write_M=0; beq/sw/jr -> reg_write_M=0.
